// File: rtl/riscv_pkg.sv
// Shared RV32I field widths, instruction formats and encoder FSM states.
package RISCV_PKG;

  localparam int INSTRUCTION_SIZE = 32;
  localparam int IMMEDIATE_SIZE   = 32;
  localparam int OPCODE_SIZE      = 7;
  localparam int REG_ADDR_SIZE    = 5;
  localparam int FUNCT3_SIZE      = 3;
  localparam int FUNCT7_SIZE      = 7;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_format_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } encoder_state_t;

endpackage

// File: rtl/instruction_encoder_range_checker.sv
// Decides whether an immediate can be represented exactly by the chosen
// instruction format, so the packed word decodes back to the same value.
module immediate_range_checker
  import RISCV_PKG::*;
(
  input  logic [2:0]                Format,
  input  logic [IMMEDIATE_SIZE-1:0] Immediate,
  output logic                      Legal
);

  logic w_upper11Same;
  logic w_upper12Same;
  logic w_upper20Same;
  logic w_lowZero;
  logic w_even;

  assign w_upper11Same = (&Immediate[31:11]) | ~(|Immediate[31:11]);
  assign w_upper12Same = (&Immediate[31:12]) | ~(|Immediate[31:12]);
  assign w_upper20Same = (&Immediate[31:20]) | ~(|Immediate[31:20]);
  assign w_lowZero     = ~(|Immediate[11:0]);
  assign w_even        = ~Immediate[0];

  // Pick the rule for the incoming format; encodings 6 and 7 are never legal
  always_comb begin
    Legal = 1'b0;
    case (Format)
      FMT_R:        Legal = 1'b1;
      FMT_I, FMT_S: Legal = w_upper11Same;
      FMT_B:        Legal = w_upper12Same && w_even;
      FMT_U:        Legal = w_lowZero;
      FMT_J:        Legal = w_upper20Same && w_even;
      default:      Legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields into instruction words and streams each legal
// word out with a sequential instruction-memory byte address.
module instruction_encoder
  import RISCV_PKG::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Start,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [2:0]                    Format,
  input  logic [OPCODE_SIZE-1:0]        Opcode,
  input  logic [REG_ADDR_SIZE-1:0]      Rd,
  input  logic [REG_ADDR_SIZE-1:0]      Rs1,
  input  logic [REG_ADDR_SIZE-1:0]      Rs2,
  input  logic [FUNCT3_SIZE-1:0]        Funct3,
  input  logic [FUNCT7_SIZE-1:0]        Funct7,
  input  logic [IMMEDIATE_SIZE-1:0]     Immediate,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [INSTRUCTION_SIZE-1:0]   Instruction,
  output logic [31:0]                   Address,
  output logic                          ImmError,
  output logic                          Full
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMEM_DEPTH - 1);

  encoder_state_t r_state;
  encoder_state_t w_nextState;

  logic [IDX_W-1:0]            r_index;
  logic                        r_outValid;
  logic                        r_immError;
  logic [INSTRUCTION_SIZE-1:0] r_instr;
  logic [31:0]                 r_addr;

  logic                        w_legal;
  logic                        w_inReady;
  logic                        w_accept;
  logic                        w_lastWord;
  logic [INSTRUCTION_SIZE-1:0] w_packed;
  logic [31:0]                 w_addr;

  immediate_range_checker u_rangeChecker (
    .Format    (Format),
    .Immediate (Immediate),
    .Legal     (w_legal)
  );

  assign w_inReady  = (r_state == ST_RUN) && (!r_outValid || OutReady);
  assign w_accept   = InValid && w_inReady && !Start;
  assign w_lastWord = (r_index == LAST_IDX);
  assign w_addr     = BASE_ADDR + (32'(r_index) << 2);

  // Scatter the immediate and register fields into the RV32I bit layout of the format
  always_comb begin
    w_packed = '0;
    case (Format)
      FMT_R:   w_packed = {Funct7, Rs2, Rs1, Funct3, Rd, Opcode};
      FMT_I:   w_packed = {Immediate[11:0], Rs1, Funct3, Rd, Opcode};
      FMT_S:   w_packed = {Immediate[11:5], Rs2, Rs1, Funct3, Immediate[4:0], Opcode};
      FMT_B:   w_packed = {Immediate[12], Immediate[10:5], Rs2, Rs1, Funct3,
                           Immediate[4:1], Immediate[11], Opcode};
      FMT_U:   w_packed = {Immediate[31:12], Rd, Opcode};
      FMT_J:   w_packed = {Immediate[20], Immediate[10:1], Immediate[11],
                           Immediate[19:12], Rd, Opcode};
      default: w_packed = '0;
    endcase
  end

  // Session state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Start always reopens a session; accepting the last legal word closes it
  always_comb begin
    w_nextState = r_state;
    if (Start) begin
      w_nextState = ST_RUN;
    end else if ((r_state == ST_RUN) && w_accept && w_legal && w_lastWord) begin
      w_nextState = ST_FULL;
    end
  end

  // Output word register, word index and sticky drop flag; a new word may load while the old one drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_instr    <= '0;
      r_addr     <= BASE_ADDR;
      r_immError <= 1'b0;
      r_index    <= '0;
    end else if (Start) begin
      r_outValid <= 1'b0;
      r_immError <= 1'b0;
      r_index    <= '0;
    end else begin
      if (w_accept && w_legal) begin
        r_instr    <= w_packed;
        r_addr     <= w_addr;
        r_outValid <= 1'b1;
        r_index    <= r_index + 1'b1;
      end else if (OutReady) begin
        r_outValid <= 1'b0;
      end
      if (w_accept && !w_legal) begin
        r_immError <= 1'b1;
      end
    end
  end

  assign InReady     = w_inReady;
  assign OutValid    = r_outValid;
  assign Instruction = r_instr;
  assign Address     = r_addr;
  assign ImmError    = r_immError;
  assign Full        = (r_state == ST_FULL);

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios plus a randomized run
// checked against an arithmetic reference of the encoding and stream rules.
module tb_instruction_encoder;
  import RISCV_PKG::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fields_t;

  logic        clk = 1'b0;
  logic        reset, Start, InValid, InReady, OutValid, OutReady, ImmError, Full;
  logic [2:0]  Format, Funct3;
  logic [6:0]  Opcode, Funct7;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [31:0] Immediate, Instruction, Address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Start(Start), .InValid(InValid), .InReady(InReady),
    .Format(Format), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Funct3(Funct3), .Funct7(Funct7), .Immediate(Immediate),
    .OutValid(OutValid), .OutReady(OutReady), .Instruction(Instruction),
    .Address(Address), .ImmError(ImmError), .Full(Full)
  );

  function automatic fields_t mkFields(input logic [2:0] fmt, input logic [6:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] imm);
    fields_t f;
    f.fmt = fmt; f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
    f.f3 = f3; f.f7 = f7; f.imm = imm;
    return f;
  endfunction

  // Representability by numeric range of the immediate, per format
  function automatic bit refLegal(input logic [2:0] fmt, input logic [31:0] imm);
    int si;
    si = imm;
    case (fmt)
      3'd0:       return 1'b1;
      3'd1, 3'd2: return (si >= -2048) && (si <= 2047);
      3'd3:       return (si >= -4096) && (si <= 4095) && (imm % 2 == 0);
      3'd4:       return (imm % 4096) == 0;
      3'd5:       return (si >= -1048576) && (si <= 1048575) && (imm % 2 == 0);
      default:    return 1'b0;
    endcase
  endfunction

  // Instruction word built with place-value arithmetic
  function automatic logic [31:0] refEncode(input fields_t f);
    longint unsigned w, im, rd, rs1, rs2, f3, f7;
    im = f.imm; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2; f3 = f.f3; f7 = f.f7;
    w = f.op;
    case (f.fmt)
      3'd0: w += rd*128 + f3*4096 + rs1*32768 + rs2*1048576 + f7*33554432;
      3'd1: w += rd*128 + f3*4096 + rs1*32768 + (im % 4096)*1048576;
      3'd2: w += (im % 32)*128 + f3*4096 + rs1*32768 + rs2*1048576 + ((im/32) % 128)*33554432;
      3'd3: w += ((im/2048) % 2)*128 + ((im/2) % 16)*256 + f3*4096 + rs1*32768 + rs2*1048576
                 + ((im/32) % 64)*33554432 + ((im/4096) % 2)*64'd2147483648;
      3'd4: w += rd*128 + (im/4096)*4096;
      3'd5: w += rd*128 + ((im/4096) % 256)*4096 + ((im/2048) % 2)*1048576
                 + ((im/2) % 1024)*2097152 + ((im/1048576) % 2)*64'd2147483648;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Immediate generator as a decoder would implement it
  function automatic logic [31:0] refImmGen(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd1:    return {{20{w[31]}}, w[31:20]};
      3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    return {w[31:12], 12'b0};
      3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic fields_t randFields();
    fields_t f;
    logic [31:0] r;
    logic signed [31:0] t;
    f.fmt = 3'($urandom_range(0, 7));
    f.op = 7'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom);
    f.rs2 = 5'($urandom); f.f3 = 3'($urandom); f.f7 = 7'($urandom);
    r = $urandom;
    case (f.fmt)
      3'd1, 3'd2: begin t = r << 20; f.imm = t >>> 20; end
      3'd3:       begin t = r << 19; f.imm = (t >>> 19) & ~32'd1; end
      3'd4:       f.imm = r & 32'hFFFF_F000;
      3'd5:       begin t = r << 11; f.imm = (t >>> 11) & ~32'd1; end
      default:    f.imm = r;
    endcase
    if ($urandom_range(0, 4) == 0) f.imm = $urandom;
    return f;
  endfunction

  function automatic fields_t randLegal();
    fields_t f;
    f = randFields();
    while (!refLegal(f.fmt, f.imm)) f = randFields();
    return f;
  endfunction

  task automatic applyFields(input fields_t f);
    Format = f.fmt; Opcode = f.op; Rd = f.rd; Rs1 = f.rs1; Rs2 = f.rs2;
    Funct3 = f.f3; Funct7 = f.f7; Immediate = f.imm;
  endtask

  task automatic pulseStart();
    Start = 1'b1; InValid = 1'b0;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; OutReady = 1'b1; InValid = 1'b1;
    applyFields(mkFields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    @(negedge clk); @(negedge clk); #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_OutValid got %b want 0", OutValid); end
    checks++; if (Instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_Instruction got %h want 0", Instruction); end
    checks++; if (Address !== BASE) begin errors++; $display("[TB] FAIL reset_Address got %h want %h", Address, BASE); end
    checks++; if (ImmError !== 1'b0) begin errors++; $display("[TB] FAIL reset_ImmError got %b want 0", ImmError); end
    checks++; if (Full !== 1'b0) begin errors++; $display("[TB] FAIL reset_Full got %b want 0", Full); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_InReady got %b want 0", InReady); end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (InReady !== 1'b0) begin errors++; $display("[TB] FAIL idle_InReady got %b want 0", InReady); end
    checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_OutValid got %b want 0", OutValid); end
    InValid = 1'b0;
  endtask

  task automatic test_encode();
    fields_t     tbl[5];
    logic [31:0] expW[5];
    logic [31:0] expA[5];
    tbl[0] = mkFields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tbl[1] = mkFields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tbl[2] = mkFields(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    tbl[3] = mkFields(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    tbl[4] = mkFields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    expW[0] = 32'h0050_0093; expW[1] = 32'h0020_A423; expW[2] = 32'hFE00_0EE3;
    expW[3] = 32'h0010_00EF; expW[4] = 32'h1234_52B7;
    expA[0] = 32'h0; expA[1] = 32'h4; expA[2] = 32'h8; expA[3] = 32'hC; expA[4] = 32'h0;
    OutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 4) pulseStart();
      applyFields(tbl[i]); InValid = 1'b1; #1;
      checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL enc%0d_InReady got %b want 1", i, InReady); end
      @(negedge clk); InValid = 1'b0; #1;
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL enc%0d_OutValid got %b want 1", i, OutValid); end
      checks++; if (Instruction !== expW[i]) begin errors++; $display("[TB] FAIL enc%0d_Instruction got %h want %h", i, Instruction, expW[i]); end
      checks++; if (Address !== expA[i]) begin errors++; $display("[TB] FAIL enc%0d_Address got %h want %h", i, Address, expA[i]); end
      checks++; if (refImmGen(tbl[i].fmt, Instruction) !== tbl[i].imm) begin errors++; $display("[TB] FAIL enc%0d_roundtrip got %h want %h", i, refImmGen(tbl[i].fmt, Instruction), tbl[i].imm); end
      checks++; if (Full !== (i == 3)) begin errors++; $display("[TB] FAIL enc%0d_Full got %b want %b", i, Full, (i == 3)); end
      if (i == 3) begin
        InValid = 1'b1; #1;
        checks++; if (InReady !== 1'b0) begin errors++; $display("[TB] FAIL enc_full_InReady got %b want 0", InReady); end
        InValid = 1'b0;
      end
    end
  endtask

  task automatic test_illegal();
    fields_t     seq[5];
    bit          legal[5];
    logic [31:0] expW[5];
    logic [31:0] expA[5];
    seq[0] = mkFields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    seq[1] = mkFields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    seq[2] = mkFields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    seq[3] = mkFields(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    seq[4] = mkFields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    legal[0] = 1; legal[1] = 0; legal[2] = 0; legal[3] = 0; legal[4] = 1;
    expW[0] = 32'h0050_0093; expW[4] = 32'h0020_A423; expA[0] = 32'h0; expA[4] = 32'h4;
    OutReady = 1'b1;
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      applyFields(seq[i]); InValid = 1'b1;
      @(negedge clk); InValid = 1'b0; #1;
      checks++; if (OutValid !== legal[i]) begin errors++; $display("[TB] FAIL ill%0d_OutValid got %b want %b", i, OutValid, legal[i]); end
      checks++; if (ImmError !== (i >= 1)) begin errors++; $display("[TB] FAIL ill%0d_ImmError got %b want %b", i, ImmError, (i >= 1)); end
      if (legal[i]) begin
        checks++; if (Instruction !== expW[i]) begin errors++; $display("[TB] FAIL ill%0d_Instruction got %h want %h", i, Instruction, expW[i]); end
        checks++; if (Address !== expA[i]) begin errors++; $display("[TB] FAIL ill%0d_Address got %h want %h", i, Address, expA[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    fields_t fa, fb, fc;
    fa = mkFields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    fb = mkFields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    fc = mkFields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    OutReady = 1'b1;
    pulseStart();
    OutReady = 1'b0; applyFields(fa); InValid = 1'b1; #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_InReady got %b want 1", InReady); end
    @(negedge clk); applyFields(fb);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (InReady !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_InReady got %b want 0", k, InReady); end
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL bp%0d_OutValid got %b want 1", k, OutValid); end
      checks++; if (Instruction !== 32'h0050_0093) begin errors++; $display("[TB] FAIL bp%0d_Instruction got %h want 00500093", k, Instruction); end
      checks++; if (Address !== 32'h0) begin errors++; $display("[TB] FAIL bp%0d_Address got %h want 0", k, Address); end
      @(negedge clk);
    end
    OutReady = 1'b1; #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_InReady got %b want 1", InReady); end
    @(negedge clk); applyFields(fc); #1;
    checks++; if (Instruction !== 32'h0020_A423 || Address !== 32'h4) begin errors++; $display("[TB] FAIL bp_second got %h@%h want 0020a423@4", Instruction, Address); end
    @(negedge clk); InValid = 1'b0; #1;
    checks++; if (Instruction !== 32'h1234_52B7 || Address !== 32'h8 || OutValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_third got %h@%h v%b want 123452b7@8 v1", Instruction, Address, OutValid); end
  endtask

  task automatic test_full();
    fields_t f;
    logic [31:0] w;
    OutReady = 1'b1;
    pulseStart();
    for (int k = 0; k < 6; k++) begin
      f = randLegal(); w = refEncode(f);
      applyFields(f); InValid = 1'b1; #1;
      checks++; if (InReady !== (k < DEPTH)) begin errors++; $display("[TB] FAIL full%0d_InReady got %b want %b", k, InReady, (k < DEPTH)); end
      @(negedge clk); #1;
      checks++; if (OutValid !== (k < DEPTH)) begin errors++; $display("[TB] FAIL full%0d_OutValid got %b want %b", k, OutValid, (k < DEPTH)); end
      checks++; if (Full !== (k >= DEPTH - 1)) begin errors++; $display("[TB] FAIL full%0d_Full got %b want %b", k, Full, (k >= DEPTH - 1)); end
      if (k < DEPTH) begin
        checks++; if (Instruction !== w || Address !== BASE + 32'(4 * k)) begin errors++; $display("[TB] FAIL full%0d_word got %h@%h want %h@%h", k, Instruction, Address, w, BASE + 32'(4 * k)); end
      end
    end
    pulseStart(); #1;
    checks++; if (Full !== 1'b0) begin errors++; $display("[TB] FAIL full_restart_Full got %b want 0", Full); end
    f = randLegal(); w = refEncode(f);
    applyFields(f); InValid = 1'b1;
    @(negedge clk); InValid = 1'b0; #1;
    checks++; if (Instruction !== w || Address !== BASE) begin errors++; $display("[TB] FAIL full_restart_word got %h@%h want %h@%h", Instruction, Address, w, BASE); end
  endtask

  task automatic test_reset_midsession();
    OutReady = 1'b1;
    pulseStart();
    applyFields(mkFields(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3)); InValid = 1'b1;
    @(negedge clk);
    OutReady = 1'b0; applyFields(randLegal());
    @(negedge clk); applyFields(randLegal());
    @(negedge clk); #1;
    checks++; if (OutValid !== 1'b1 || ImmError !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre got v%b e%b want v1 e1", OutValid, ImmError); end
    reset = 1'b1; #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_OutValid got %b want 0", OutValid); end
    checks++; if (Instruction !== 32'h0 || Address !== BASE) begin errors++; $display("[TB] FAIL midrst_word got %h@%h want 0@%h", Instruction, Address, BASE); end
    checks++; if (ImmError !== 1'b0 || Full !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags got e%b f%b want e0 f0", ImmError, Full); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("[TB] FAIL midrst_InReady got %b want 0", InReady); end
    @(negedge clk); reset = 1'b0; OutReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (InReady !== 1'b0 || OutValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle%0d got r%b v%b want r0 v0", k, InReady, OutValid); end
    end
    pulseStart(); #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_start_InReady got %b want 1", InReady); end
    InValid = 1'b0;
  endtask

  task automatic test_random();
    fields_t     f;
    bit          mRun, mFull, mOV, mErr, expReady, acc;
    int          mIdx;
    logic [31:0] mInstr, mAddr, mImm;
    logic [2:0]  mFmt;
    mRun = 0; mFull = 0; mOV = 0; mErr = 0; mIdx = 0;
    mInstr = '0; mAddr = '0; mImm = '0; mFmt = '0;
    for (int c = 0; c < 3000; c++) begin
      f = randFields(); applyFields(f);
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      Start    = (c == 0) || ($urandom_range(0, 59) == 0);
      #1;
      expReady = mRun && (!mOV || OutReady);
      if (c > 0) begin
        checks++; if (InReady !== expReady) begin errors++; $display("[TB] FAIL rnd%0d_InReady got %b want %b", c, InReady, expReady); end
        checks++; if (OutValid !== mOV) begin errors++; $display("[TB] FAIL rnd%0d_OutValid got %b want %b", c, OutValid, mOV); end
        checks++; if (Full !== mFull || ImmError !== mErr) begin errors++; $display("[TB] FAIL rnd%0d_flags got f%b e%b want f%b e%b", c, Full, ImmError, mFull, mErr); end
        if (mOV) begin
          checks++; if (Instruction !== mInstr || Address !== mAddr) begin errors++; $display("[TB] FAIL rnd%0d_word got %h@%h want %h@%h", c, Instruction, Address, mInstr, mAddr); end
          if (mFmt != 3'd0) begin
            checks++; if (refImmGen(mFmt, Instruction) !== mImm) begin errors++; $display("[TB] FAIL rnd%0d_roundtrip got %h want %h", c, refImmGen(mFmt, Instruction), mImm); end
          end
        end
      end
      acc = !Start && InValid && expReady;
      if (Start) begin
        mRun = 1; mFull = 0; mIdx = 0; mErr = 0; mOV = 0;
      end else begin
        if (acc && refLegal(f.fmt, f.imm)) begin
          mInstr = refEncode(f); mAddr = BASE + 32'(4 * mIdx); mOV = 1;
          mFmt = f.fmt; mImm = f.imm; mIdx++;
          if (mIdx == DEPTH) begin mFull = 1; mRun = 0; end
        end else if (OutReady) begin
          mOV = 0;
        end
        if (acc && !refLegal(f.fmt, f.imm)) mErr = 1;
      end
      @(negedge clk);
    end
    Start = 1'b0; InValid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; Start = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    applyFields(mkFields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    test_reset();
    test_encode();
    test_illegal();
    test_backpressure();
    test_full();
    test_reset_midsession();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

- Packs decoded RV32I fields (format, opcode, registers, funct3/funct7, 32-bit immediate) into a 32-bit instruction word, the inverse of the immediate generator.
- Range-checks each immediate and emits each legal word with a sequential instruction-memory byte address over a valid/ready stream.
- Sits between the bench/boot-loader front end and instruction-memory preload.
- Round-trip requirement: immediate generator output on the emitted word equals the input immediate, for every legal input.

## Interface
- IMEM_DEPTH, 256: capacity in 32-bit words; power of two, ≥ 2.
- BASE_ADDR, 32'h0000_0000: byte address of the first emitted word; 4-byte aligned.

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- Start  input  1  single-cycle pulse; (re)starts a load session
- InValid  input  1  input fields valid
- InReady  output  1  encoder accepts fields this cycle
- Format  input  3  instr_format_t: R, I, S, B, U, J
- Opcode  input  7  opcode field
- Rd, Rs1, Rs2  input  5 each  register fields
- Funct3  input  3  funct3 field
- Funct7  input  7  funct7 field, R-format only
- Immediate  input  32  full-width immediate
- OutValid  output  1  Instruction/Address valid
- OutReady  input  1  downstream accepts word
- Instruction  output  32  encoded word
- Address  output  32  byte address = BASE_ADDR + 4*index
- ImmError  output  1  sticky: at least one input dropped since Start
- Full  output  1  IMEM_DEPTH words accepted this session

## Operation
- States: IDLE, RUN, FULL. Reset → IDLE.
- Start in any state → RUN:
  - clears word index, ImmError, Full and OutValid; a pending output word is discarded.
  - Start has priority over a same-cycle input handshake, which is ignored.
- Input handshake = InValid && InReady.
  - InReady = (state == RUN) && (!OutValid || OutReady).
- Packing:
  - R: Funct7|Rs2|Rs1|Funct3|Rd|Opcode.
  - I: Imm[11:0]|Rs1|Funct3|Rd|Opcode.
  - S: Imm[11:5]|Rs2|Rs1|Funct3|Imm[4:0]|Opcode.
  - B: Imm[12]|Imm[10:5]|Rs2|Rs1|Funct3|Imm[4:1]|Imm[11]|Opcode.
  - U: Imm[31:12]|Rd|Opcode.
  - J: Imm[20]|Imm[10:1]|Imm[11]|Imm[19:12]|Rd|Opcode.
- Legality; a field not used by the format is ignored:
  - I/S: Imm[31:11] all equal.
  - B: Imm[31:12] all equal and Imm[0] = 0.
  - J: Imm[31:20] all equal and Imm[0] = 0.
  - U: Imm[11:0] = 0.
  - R: always legal.
  - Format 6/7: illegal.
- Illegal accepted input:
  - word dropped; OutValid not set, index unchanged.
  - ImmError set, held until Start or reset.
- Legal accepted input:
  - Instruction and Address registered; OutValid set.
  - index increments.
  - Accepting word IMEM_DEPTH-1 (last word) → FULL, Full = 1.
- FULL: no further input accepted; the final word still drains via the output handshake.
- Output word held stable while OutValid && !OutReady.

## Timing
- Reset values: OutValid = 0, Instruction = 0, Address = BASE_ADDR, ImmError = 0, Full = 0, InReady = 0, state IDLE, index 0.
- Latency: fields accepted at edge N appear on Instruction at edge N (registered), visible in cycle N+1.
- Throughput: one word per cycle while OutReady is held high.
- Simultaneous output drain and new input accept in one cycle is required; no bubble.
- Reset mid-session: immediate return to reset values; the in-flight word is lost.

## Structure
- RISCV_PKG gains:
  - typedef enum logic [2:0] instr_format_t {FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
  - REG_ADDR_SIZE = 5, FUNCT3_SIZE = 3, FUNCT7_SIZE = 7.
  - Existing INSTRUCTION_SIZE, IMMEDIATE_SIZE and OPCODE_SIZE are reused.
- Sub-module immediate_range_checker (combinational: Format, Immediate → Legal) holds all legality rules.
- Packing mux and FSM live in the top module.

## Test plan
- Start, then I-type addi: Opcode 0x13, Rd 1, Rs1 0, Funct3 0, Imm 5 → Instruction 0x00500093 at Address 0x0; then S-type sw: Opcode 0x23, Rs1 1, Rs2 2, Funct3 2, Imm 8 → 0x0020A423 at Address 0x4.
- B-type beq x0,x0, Imm −4 → 0xFE000EE3; J-type jal, Rd 1, Imm 0x800 → 0x001000EF; U-type lui, Rd 5, Imm 0x12345000 → 0x123452B7. Each word fed to the immediate generator returns the input Imm.
- B-type with Imm 3, then U-type with Imm 0x1 → both dropped, ImmError = 1, next legal word still gets the next sequential Address.
- Back-pressure: hold OutReady = 0 for 5 cycles with InValid = 1 → Instruction/Address stable, InReady = 0, exactly one word accepted; release → one word per cycle, no loss or duplication.
- IMEM_DEPTH = 4: stream 6 legal words → 4 emitted at 0x0–0xC, Full = 1 after the 4th accept, InReady = 0; Start → Full = 0, Address restarts at BASE_ADDR.
- Assert reset while OutValid = 1 with a word stalled → all outputs at reset values the same cycle; InReady stays 0 until Start.
